// File: rtl/c61_pkg.sv
// Shared widths and types for the c61 register-file operand fetch block.
package c61_pkg;

  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int OPW   = 4;
  localparam int NREGS = 2 ** AW;

  typedef logic [AW-1:0]  reg_idx_t;
  typedef logic [DW-1:0]  word_t;
  typedef logic [OPW-1:0] op_t;

  // Contents of the operand register handed to execute.
  typedef struct packed {
    word_t    a;
    word_t    b;
    reg_idx_t rw;
    logic     wen;
    op_t      op;
  } ex_bundle_t;

endpackage

// File: rtl/regfile_opfetch_if.sv
// Decode, execute, writeback and regfile-port signals of regfile_opfetch.
interface regfile_opfetch_if;
  import c61_pkg::*;

  logic     dec_valid;
  logic     dec_ready;
  reg_idx_t dec_ra;
  reg_idx_t dec_rb;
  reg_idx_t dec_rw;
  logic     dec_wen;
  op_t      dec_op;

  reg_idx_t ra_sel;
  reg_idx_t rb_sel;
  word_t    ra;
  word_t    rb;
  reg_idx_t rw_sel;
  word_t    wd;
  logic     we;

  logic     ex_valid;
  logic     ex_ready;
  word_t    ex_a;
  word_t    ex_b;
  reg_idx_t ex_rw;
  logic     ex_wen;
  op_t      ex_op;

  logic     wb_valid;
  reg_idx_t wb_rw;
  word_t    wb_data;

  modport slave (
    input  dec_valid, dec_ra, dec_rb, dec_rw, dec_wen, dec_op,
    output dec_ready,
    output ra_sel, rb_sel, rw_sel, wd, we,
    input  ra, rb,
    output ex_valid, ex_a, ex_b, ex_rw, ex_wen, ex_op,
    input  ex_ready,
    input  wb_valid, wb_rw, wb_data
  );

  modport master (
    output dec_valid, dec_ra, dec_rb, dec_rw, dec_wen, dec_op,
    input  dec_ready,
    input  ra_sel, rb_sel, rw_sel, wd, we,
    output ra, rb,
    input  ex_valid, ex_a, ex_b, ex_rw, ex_wen, ex_op,
    output ex_ready,
    output wb_valid, wb_rw, wb_data
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy bit per register: set on dispatch of a writer, cleared on commit.
module regfile_scoreboard
  import c61_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t look_a,
  input  reg_idx_t look_b,
  input  reg_idx_t look_w,
  output logic     busy_a,
  output logic     busy_b,
  output logic     busy_w
);

  logic [NREGS-1:0] busy;

  // NOTE: state uses non-blocking assignments so every reader sees the pre-edge value.
  // Set is applied after clear: a new writer to a just-committed index stays busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

  assign busy_a = busy[look_a];
  assign busy_b = busy[look_b];
  assign busy_w = busy[look_w];

endmodule

// File: rtl/regfile_opfetch.sv
// Operand fetch, hazard stall and writeback commit in front of the c61 regfile.
// Define REGFILE_OPFETCH_BYPASS_EN to forward the commit register into operands.
module regfile_opfetch
  import c61_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  regfile_opfetch_if.slave  bus
);

  logic       pend_v;
  reg_idx_t   pend_rw;
  word_t      pend_data;
  logic       fwd_a;
  logic       fwd_b;
  logic       busy_a;
  logic       busy_b;
  logic       busy_w;
  logic       hz;
  logic       dispatch;
  word_t      opnd_a;
  word_t      opnd_b;
  logic       ex_valid_q;
  ex_bundle_t ex_q;

  // Commit register: one cycle between writeback arrival and the regfile write.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v    <= 1'b0;
      pend_rw   <= '0;
      pend_data <= '0;
    end else begin
      pend_v <= bus.wb_valid;
      if (bus.wb_valid) begin
        pend_rw   <= bus.wb_rw;
        pend_data <= bus.wb_data;
      end
    end
  end

  assign bus.we     = pend_v;
  assign bus.rw_sel = pend_rw;
  assign bus.wd     = pend_data;

  assign bus.ra_sel = bus.dec_ra;
  assign bus.rb_sel = bus.dec_rb;

`ifdef REGFILE_OPFETCH_BYPASS_EN
  assign fwd_a = pend_v && (pend_rw == bus.dec_ra);
  assign fwd_b = pend_v && (pend_rw == bus.dec_rb);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  regfile_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (dispatch && bus.dec_wen),
    .set_idx (bus.dec_rw),
    .clr_en  (pend_v),
    .clr_idx (pend_rw),
    .look_a  (bus.dec_ra),
    .look_b  (bus.dec_rb),
    .look_w  (bus.dec_rw),
    .busy_a  (busy_a),
    .busy_b  (busy_b),
    .busy_w  (busy_w)
  );

  // WAW looks at busy before this cycle's clear, so the commit must land first.
  assign hz = (busy_a && !fwd_a) || (busy_b && !fwd_b) || (bus.dec_wen && busy_w);

  assign bus.dec_ready = !hz && (!ex_valid_q || bus.ex_ready);
  assign dispatch      = bus.dec_valid && bus.dec_ready;

  assign opnd_a = fwd_a ? pend_data : bus.ra;
  assign opnd_b = fwd_b ? pend_data : bus.rb;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (dispatch) begin
      ex_valid_q <= 1'b1;
      ex_q.a     <= opnd_a;
      ex_q.b     <= opnd_b;
      ex_q.rw    <= bus.dec_rw;
      ex_q.wen   <= bus.dec_wen;
      ex_q.op    <= bus.dec_op;
    end else if (bus.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_a     = ex_q.a;
  assign bus.ex_b     = ex_q.b;
  assign bus.ex_rw    = ex_q.rw;
  assign bus.ex_wen   = ex_q.wen;
  assign bus.ex_op    = ex_q.op;

endmodule
